n64_bank_scheduler: RTL
=======================

Name: n64_bank_scheduler

Overview:
Shares the single bank-addressed memory port between the N64 PI requester and the on-board CPU requester. Both requesters present already-decoded accesses: bank code, translated address and prefetch flag. For prefetchable N64 reads, the block speculatively fetches the next halfword into a one-entry buffer, so sequential PI reads can be answered without a memory round trip.

Parameters:
ADDR_W, 26, translated address width
DATA_W, 16, data width (PI halfword)
PREFETCH_ENABLE, 1, 0 disables speculative fetch and buffer hits

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  synchronous active-low reset
i_n64_request  in  1  N64 access pending, held until o_n64_ack
i_n64_write  in  1  1 = write
i_n64_bank  in  4  decoded bank (0 invalid, 1 ROM, 2 CART, 3 EEPROM)
i_n64_prefetch  in  1  bank permits speculative read
i_n64_address  in  ADDR_W  translated address
i_n64_wdata  in  DATA_W  write data
o_n64_ack  out  1  one-cycle completion pulse
o_n64_rdata  out  DATA_W  read data, valid with o_n64_ack
i_cpu_request, i_cpu_write, i_cpu_bank[3:0], i_cpu_address[ADDR_W], i_cpu_wdata[DATA_W]  in  as above  CPU access
o_cpu_ack  out  1  one-cycle completion pulse
o_cpu_rdata  out  DATA_W  read data, valid with o_cpu_ack
o_mem_request  out  1  memory access, held until i_mem_ack
o_mem_write  out  1  1 = write
o_mem_bank  out  4  target bank
o_mem_address  out  ADDR_W  target address
o_mem_wdata  out  DATA_W  write data
i_mem_ack  in  1  one-cycle completion
i_mem_rdata  in  DATA_W  valid with i_mem_ack

Behaviour:
- Reset (i_reset_n=0 at posedge): state IDLE; all outputs 0; prefetch buffer invalid; last_grant=CPU, so N64 wins the first tie. A reset mid-access abandons the access; an i_mem_ack arriving in IDLE is ignored.
- States: IDLE, N64_ACCESS, CPU_ACCESS, PREFETCH.
- IDLE arbitration, evaluated each cycle:
  - Both requesting: grant the requester not served last (round-robin).
  - One requesting: grant it.
  - Grant registers the mem fields, asserts o_mem_request next cycle, and moves to the *_ACCESS state.
- Bank 0 request: no memory access; ack 1 cycle after the grant with rdata 16'hFFFF; writes are dropped.
- *_ACCESS: mem fields stay stable while o_mem_request=1.
  - On i_mem_ack: drop o_mem_request; pulse the requester ack in the next cycle; rdata = captured i_mem_rdata (0 for writes).
  - Then go to PREFETCH or IDLE.
- Prefetch trigger: completed N64 read with i_n64_prefetch=1 and PREFETCH_ENABLE=1 -> PREFETCH.
  - Issue a read at address+2, modulo 2^ADDR_W (wraps to 0), same bank.
  - On i_mem_ack: buffer {valid=1, bank, address, data}, then IDLE.
  - PREFETCH is never aborted; pending requests wait.
- Buffer hit, in IDLE: N64 read with bank and address equal to the valid buffer entry, with N64 granted.
  - o_n64_ack pulses exactly 1 cycle after the grant cycle, rdata = buffer data; no memory access.
  - Then PREFETCH for address+2; last_grant=N64.
- Invalidation: any write, from either requester, to the buffered bank clears valid when granted. An N64 read miss also clears valid.
- Simultaneous write-hit on the same cycle as a buffered address: the write wins; the buffer is invalidated.
- At most one outstanding memory access; acks never overlap.
- Requester handshake rule: the request may deassert only after ack. A new request may be presented in the cycle after ack.

Decomposition:
- Shared package: bank codes (BANK_INVALID/ROM/CART/EEPROM) and the state enum, shared with the bank decoder.
- Natural sub-module: n64_prefetch_buffer. Holds the one-entry valid/bank/address/data store, with the hit compare, load and invalidate ports.

Test Plan:
- N64 read bank1 addr 0x000100, prefetch=1, mem acks after 3 cycles with 0x1234 -> o_n64_ack with 0x1234; then o_mem_address=0x000102 read issued; buffer loaded with 0x5678.
- Next N64 read addr 0x000102 -> ack 1 cycle after grant with 0x5678, no o_mem_request for 0x102; prefetch of 0x104 follows.
- N64 and CPU request same cycle from reset, then both again -> N64 served first, CPU second, then N64 (alternation).
- Buffer holds bank1 0x104; CPU write bank1 0x104 = 0xAAAA; then N64 read 0x104 -> memory read issued (miss), not buffer data.
- N64 read bank1 addr 0x3FFFFFE with prefetch -> prefetch address 0x0000000; CPU read bank0 -> ack with 0xFFFF, o_mem_request stays 0.
- Assert i_reset_n=0 while o_mem_request=1 in PREFETCH -> next cycle all outputs 0, buffer invalid; late i_mem_ack produces no requester ack.

Source files
------------

// File: rtl/n64_bank_scheduler_pkg.sv
// rtl/n64_bank_scheduler_pkg.sv - bank codes and scheduler state encoding
package n64_bank_scheduler_pkg;

  localparam logic [3:0] BANK_INVALID = 4'd0;
  localparam logic [3:0] BANK_ROM     = 4'd1;
  localparam logic [3:0] BANK_CART    = 4'd2;
  localparam logic [3:0] BANK_EEPROM  = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_N64_ACCESS,
    ST_CPU_ACCESS,
    ST_PREFETCH
  } sched_state_t;

endpackage

// File: rtl/n64_bank_scheduler_prefetch_buffer.sv
// rtl/n64_bank_scheduler_prefetch_buffer.sv - one-entry speculative read buffer
module n64_prefetch_buffer #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_load,
  input  logic [3:0]        i_load_bank,
  input  logic [ADDR_W-1:0] i_load_address,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_invalidate,
  input  logic [3:0]        i_lookup_bank,
  input  logic [ADDR_W-1:0] i_lookup_address,
  output logic              o_hit,
  output logic              o_valid,
  output logic [3:0]        o_bank,
  output logic [DATA_W-1:0] o_data
);

  logic [ADDR_W-1:0] address_q;

  // Entry store; invalidation takes priority over a simultaneous load
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_valid   <= 1'b0;
      o_bank    <= '0;
      address_q <= '0;
      o_data    <= '0;
    end else if (i_invalidate) begin
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_valid   <= 1'b1;
      o_bank    <= i_load_bank;
      address_q <= i_load_address;
      o_data    <= i_load_data;
    end
  end

  assign o_hit = o_valid && (o_bank == i_lookup_bank) && (address_q == i_lookup_address);

endmodule

// File: rtl/n64_bank_scheduler.sv
// rtl/n64_bank_scheduler.sv - arbitrates N64 PI and CPU onto one memory port with prefetch
import n64_bank_scheduler_pkg::*;

module n64_bank_scheduler #(
  parameter int ADDR_W          = 26,
  parameter int DATA_W          = 16,
  parameter int PREFETCH_ENABLE = 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_n64_request,
  input  logic              i_n64_write,
  input  logic [3:0]        i_n64_bank,
  input  logic              i_n64_prefetch,
  input  logic [ADDR_W-1:0] i_n64_address,
  input  logic [DATA_W-1:0] i_n64_wdata,
  output logic              o_n64_ack,
  output logic [DATA_W-1:0] o_n64_rdata,
  input  logic              i_cpu_request,
  input  logic              i_cpu_write,
  input  logic [3:0]        i_cpu_bank,
  input  logic [ADDR_W-1:0] i_cpu_address,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_mem_request,
  output logic              o_mem_write,
  output logic [3:0]        o_mem_bank,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam bit PF_ON = (PREFETCH_ENABLE != 0);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(2);

  sched_state_t state_q, state_d;
  logic last_n64_q, last_n64_d;
  logic pf_q, pf_d;
  logic mem_request_d, mem_write_d;
  logic [3:0] mem_bank_d;
  logic [ADDR_W-1:0] mem_address_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic n64_ack_d, cpu_ack_d;
  logic [DATA_W-1:0] n64_rdata_d, cpu_rdata_d;
  logic buf_hit, buf_valid, buf_load, buf_inv;
  logic [3:0] buf_bank;
  logic [DATA_W-1:0] buf_data;
  logic n64_req, cpu_req, grant_n64, grant_cpu;

  // A requester whose ack is on the wire this cycle is still holding its old request
  assign n64_req   = i_n64_request && !o_n64_ack;
  assign cpu_req   = i_cpu_request && !o_cpu_ack;
  assign grant_n64 = n64_req && (!cpu_req || !last_n64_q);
  assign grant_cpu = cpu_req && !grant_n64;

  n64_prefetch_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buffer (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_load           (buf_load),
    .i_load_bank      (o_mem_bank),
    .i_load_address   (o_mem_address),
    .i_load_data      (i_mem_rdata),
    .i_invalidate     (buf_inv),
    .i_lookup_bank    (i_n64_bank),
    .i_lookup_address (i_n64_address),
    .o_hit            (buf_hit),
    .o_valid          (buf_valid),
    .o_bank           (buf_bank),
    .o_data           (buf_data)
  );

  // Next-state, grant, memory-port and ack decisions
  always_comb begin
    state_d       = state_q;
    last_n64_d    = last_n64_q;
    pf_d          = pf_q;
    mem_request_d = o_mem_request;
    mem_write_d   = o_mem_write;
    mem_bank_d    = o_mem_bank;
    mem_address_d = o_mem_address;
    mem_wdata_d   = o_mem_wdata;
    n64_ack_d     = 1'b0;
    n64_rdata_d   = '0;
    cpu_ack_d     = 1'b0;
    cpu_rdata_d   = '0;
    buf_load      = 1'b0;
    buf_inv       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_n64) begin
          last_n64_d = 1'b1;
          if (i_n64_write) buf_inv = buf_valid && (buf_bank == i_n64_bank);
          else             buf_inv = !(PF_ON && buf_hit);
          if (!i_n64_write && PF_ON && buf_hit) begin
            n64_ack_d     = 1'b1;
            n64_rdata_d   = buf_data;
            mem_write_d   = 1'b0;
            mem_bank_d    = i_n64_bank;
            mem_address_d = i_n64_address + ADDR_STEP;
            mem_wdata_d   = '0;
            state_d       = ST_PREFETCH;
          end else if (i_n64_bank == BANK_INVALID) begin
            n64_ack_d   = 1'b1;
            n64_rdata_d = '1;
          end else begin
            mem_request_d = 1'b1;
            mem_write_d   = i_n64_write;
            mem_bank_d    = i_n64_bank;
            mem_address_d = i_n64_address;
            mem_wdata_d   = i_n64_wdata;
            pf_d          = i_n64_prefetch;
            state_d       = ST_N64_ACCESS;
          end
        end else if (grant_cpu) begin
          last_n64_d = 1'b0;
          buf_inv    = i_cpu_write && buf_valid && (buf_bank == i_cpu_bank);
          if (i_cpu_bank == BANK_INVALID) begin
            cpu_ack_d   = 1'b1;
            cpu_rdata_d = '1;
          end else begin
            mem_request_d = 1'b1;
            mem_write_d   = i_cpu_write;
            mem_bank_d    = i_cpu_bank;
            mem_address_d = i_cpu_address;
            mem_wdata_d   = i_cpu_wdata;
            state_d       = ST_CPU_ACCESS;
          end
        end
      end
      ST_N64_ACCESS: begin
        if (i_mem_ack) begin
          mem_request_d = 1'b0;
          n64_ack_d     = 1'b1;
          n64_rdata_d   = o_mem_write ? '0 : i_mem_rdata;
          if (!o_mem_write && pf_q && PF_ON) begin
            mem_address_d = o_mem_address + ADDR_STEP;
            state_d       = ST_PREFETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_CPU_ACCESS: begin
        if (i_mem_ack) begin
          mem_request_d = 1'b0;
          cpu_ack_d     = 1'b1;
          cpu_rdata_d   = o_mem_write ? '0 : i_mem_rdata;
          state_d       = ST_IDLE;
        end
      end
      ST_PREFETCH: begin
        if (!o_mem_request) begin
          mem_request_d = 1'b1;
        end else if (i_mem_ack) begin
          mem_request_d = 1'b0;
          buf_load      = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any access in flight
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q       <= ST_IDLE;
      last_n64_q    <= 1'b0;
      pf_q          <= 1'b0;
      o_mem_request <= 1'b0;
      o_mem_write   <= 1'b0;
      o_mem_bank    <= '0;
      o_mem_address <= '0;
      o_mem_wdata   <= '0;
      o_n64_ack     <= 1'b0;
      o_n64_rdata   <= '0;
      o_cpu_ack     <= 1'b0;
      o_cpu_rdata   <= '0;
    end else begin
      state_q       <= state_d;
      last_n64_q    <= last_n64_d;
      pf_q          <= pf_d;
      o_mem_request <= mem_request_d;
      o_mem_write   <= mem_write_d;
      o_mem_bank    <= mem_bank_d;
      o_mem_address <= mem_address_d;
      o_mem_wdata   <= mem_wdata_d;
      o_n64_ack     <= n64_ack_d;
      o_n64_rdata   <= n64_rdata_d;
      o_cpu_ack     <= cpu_ack_d;
      o_cpu_rdata   <= cpu_rdata_d;
    end
  end

endmodule
